serial_adder: RTL

//  Bit-serial WIDTH-bit adder built around the FullAdder cell.
//  - Loads operands A, B and carry-in Cin in parallel.
//  - Feeds one bit pair per clock, LSB first, through a single FullAdder, with the carry held in a flip-flop.
//  - Returns the WIDTH-bit Sum and carry-out Carry in parallel.
//  - Area-cheap alternative to a ripple chain of FullAdder cells; sits between an operand source and a result consumer.

---
 rtl/serial_adder_pkg.sv | 26 ++
 rtl/serial_adder_if.sv | 51 +++++
 rtl/serial_adder_fa.sv | 27 ++
 rtl/serial_adder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module : serial_adder_pkg
// Purpose: Shared types and helpers for the bit-serial adder.
//          - state_t   : FSM state encoding (IDLE=0, RUN=1, DONE=2), 2 bits
//          - cnt_width : width of the bit counter for a given operand width
// Ports  : none (package)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; it only ever has to reach width-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_if.sv
//------------------------------------------------------------------------------
// Module : serial_adder_if
// Purpose: Request/result bundle between an operand source and the serial
//          adder.
// Ports  : start, A, B, Cin       - request side (driven by the master)
//          busy, done, Sum, Carry - status/result side (driven by the slave)
// Params : WIDTH - operand/sum width in bits
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;

  // Operand source / result consumer.
  modport master (
    output start,
    output A,
    output B,
    output Cin,
    input  busy,
    input  done,
    input  Sum,
    input  Carry
  );

  // The adder itself.
  modport slave (
    input  start,
    input  A,
    input  B,
    input  Cin,
    output busy,
    output done,
    output Sum,
    output Carry
  );

endinterface : serial_adder_if

`default_nettype wire

// File: rtl/serial_adder_fa.sv
//------------------------------------------------------------------------------
// Module : FullAdder
// Purpose: One-bit full adder cell, purely combinational.
// Ports  : A, B, C (in, 1)  - addend bits and carry-in
//          Sum     (out, 1) - A ^ B ^ C
//          Carry   (out, 1) - majority(A, B, C)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module FullAdder (
  output logic Sum,
  output logic Carry,
  input  logic A,
  input  logic B,
  input  logic C
);

  logic half_sum;

  assign half_sum = A ^ B;
  assign Sum      = half_sum ^ C;
  assign Carry    = (A & B) | (C & half_sum);

endmodule : FullAdder

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module : serial_adder
// Purpose: Bit-serial WIDTH-bit adder. Operands and carry-in are loaded in
//          parallel, pushed LSB first through a single FullAdder with the
//          carry held in a flop, and the WIDTH-bit sum plus carry-out are
//          returned in parallel. One addition every WIDTH+2 cycles.
// Ports  : clk   (in, 1)  rising-edge clock
//          rst_n (in, 1)  synchronous active-low reset
//          bus   (slave)  start/A/B/Cin in; busy/done/Sum/Carry out
// Params : WIDTH - operand/sum width, >= 2
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // FSM
  state_t state;
  state_t state_nx;

  // Decoded control from the FSM
  logic accept;      // start taken in IDLE this cycle
  logic last_bit;    // final RUN cycle, result lands on this edge
  logic run_busy;
  logic done_pulse;

  // Datapath
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             cy_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic fa_sum;
  logic fa_carry;

  //--------------------------------------------------------------------------
  // The single full-adder cell; always looks at the current LSBs and carry.
  //--------------------------------------------------------------------------
  FullAdder u_fa (
    .Sum   (fa_sum),
    .Carry (fa_carry),
    .A     (a_sh[0]),
    .B     (b_sh[0]),
    .C     (cy_q)
  );

  //--------------------------------------------------------------------------
  // FSM state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  //--------------------------------------------------------------------------
  // FSM next-state and decoded outputs
  //--------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    run_busy   = 1'b0;
    done_pulse = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end

      RUN: begin
        run_busy = 1'b1;
        if (cnt == CNT_LAST) begin
          last_bit = 1'b1;
          state_nx = DONE;
        end
      end

      DONE: begin
        done_pulse = 1'b1;
        state_nx   = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Shift registers, carry flop, bit counter and result registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      cy_q    <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        a_sh <= bus.A;
        b_sh <= bus.B;
        cy_q <= bus.Cin;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 of the
        // result sits at the LSB.
        s_sh <= {fa_sum, s_sh[WIDTH-1:1]};
        cy_q <= fa_carry;
        // Wrap on the final bit so the counter never passes WIDTH-1, even
        // when WIDTH is not a power of two.
        cnt  <= last_bit ? '0 : (cnt + CNT_ONE);
      end

      // The last sum bit is still on the adder output here, so the result
      // is assembled from it directly rather than from s_sh.
      if (last_bit) begin
        sum_q   <= {fa_sum, s_sh[WIDTH-1:1]};
        carry_q <= fa_carry;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign bus.busy  = run_busy;
  assign bus.done  = done_pulse;
  assign bus.Sum   = sum_q;
  assign bus.Carry = carry_q;

endmodule : serial_adder

`default_nettype wire
